pulse_meas_scheduler: RTL

PULSE_MEAS_SCHEDULER -- requirements
Module: pulse_meas_scheduler

---
 rtl/pulse_meas_pkg.sv | 49 ++++
 rtl/sync_2ff.sv | 30 +++
 rtl/pulse_meas_scheduler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pulse_meas_pkg.sv
// Shared definitions for the pulse measurement scheduler.
//   - state_t  : scheduler FSM states
//   - NCH_DEF  : default number of measured channels
//   - CW_DEF   : default counter / result width
//   - SAT_DEF  : saturation value of the counter at the default width
//   - rr_next  : round-robin channel selector
package pulse_meas_pkg;

  localparam int NCH_DEF = 4;
  localparam int CW_DEF  = 12;
  localparam logic [CW_DEF-1:0] SAT_DEF = '1;

  // The selector works on a fixed-width mask so one function serves any NCH
  // up to MAXCH.
  localparam int MAXCH   = 32;
  localparam int MAXCH_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    COUNT  = 2'd2,
    REPORT = 2'd3
  } state_t;

  // Return the first set mask bit strictly after 'last', wrapping modulo nch.
  // If only 'last' itself is set it is found on the final wrap step, so a
  // single enabled channel is reselected every round. Returns 'last' when the
  // mask is empty (callers gate on a non-zero mask).
  function automatic int unsigned rr_next(input logic [MAXCH-1:0] mask,
                                          input int unsigned       last,
                                          input int unsigned       nch);
    int unsigned idx;
    logic        found;
    rr_next = last;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 1; i <= MAXCH; i++) begin
      if (i <= nch) begin
        idx = last + i;
        if (idx >= nch) idx = idx - nch;
        if (!found && mask[idx[MAXCH_W-1:0]]) begin
          rr_next = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, vectored.
//   i_clk : destination clock
//   i_rst : asynchronous active-high reset, clears both stages
//   i_d   : asynchronous inputs
//   o_q   : synchronized outputs, 2 cycles of latency
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pulse_meas_scheduler.sv
// Round-robin low-pulse duration measurement over NCH asynchronous inputs,
// sharing a single saturating CW-bit counter.
//   clk          : clock, all state on rising edge
//   reset        : asynchronous active-high reset
//   enable       : allows new measurements; low aborts ARM/COUNT
//   chan_mask    : eligible channels, sampled only at selection
//   signal_in    : asynchronous pulse inputs
//   res_valid    : registered result-present flag
//   res_ready    : result consumer acknowledge
//   res_chan     : channel of the presented result
//   res_duration : measured low duration in clk cycles
//   res_timeout  : result saturated or timed out waiting for a low level
//   busy         : FSM is not in IDLE
//   cur_chan     : channel currently selected
module pulse_meas_scheduler
  import pulse_meas_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW  = CW_DEF,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic [NCH-1:0] chan_mask,
  input  logic [NCH-1:0] signal_in,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [CHW-1:0] res_chan,
  output logic [CW-1:0]  res_duration,
  output logic           res_timeout,
  output logic           busy,
  output logic [CHW-1:0] cur_chan
);

  localparam logic [CW-1:0] SAT = {CW{1'b1}};

  logic [NCH-1:0]   w_sync;
  logic             w_sel_in;
  logic [MAXCH-1:0] w_mask_ext;
  logic [CHW-1:0]   w_rr;

  state_t           r_state,     w_state_nxt;
  logic [CW-1:0]    r_cnt,       w_cnt_nxt;
  logic [CHW-1:0]   r_cur,       w_cur_nxt;
  logic [CHW-1:0]   r_last,      w_last_nxt;
  logic             r_res_valid, w_res_valid_nxt;
  logic [CHW-1:0]   r_res_chan,  w_res_chan_nxt;
  logic [CW-1:0]    r_res_dur,   w_res_dur_nxt;
  logic             r_res_to,    w_res_to_nxt;

  sync_2ff #(.W(NCH)) u_sync (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (signal_in),
    .o_q   (w_sync)
  );

  assign w_sel_in   = w_sync[r_cur];
  assign w_mask_ext = MAXCH'(chan_mask);
  assign w_rr       = CHW'(rr_next(w_mask_ext, 32'(r_last), NCH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cur       <= '0;
      r_last      <= CHW'(NCH - 1);  // channel 0 is served first
      r_res_valid <= 1'b0;
      r_res_chan  <= '0;
      r_res_dur   <= '0;
      r_res_to    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cur       <= w_cur_nxt;
      r_last      <= w_last_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_res_chan  <= w_res_chan_nxt;
      r_res_dur   <= w_res_dur_nxt;
      r_res_to    <= w_res_to_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_cur_nxt       = r_cur;
    w_last_nxt      = r_last;
    w_res_valid_nxt = r_res_valid;
    w_res_chan_nxt  = r_res_chan;
    w_res_dur_nxt   = r_res_dur;
    w_res_to_nxt    = r_res_to;

    unique case (r_state)
      IDLE: begin
        if (enable && (|chan_mask)) begin
          w_cur_nxt   = w_rr;
          w_cnt_nxt   = '0;
          w_state_nxt = ARM;
        end
      end

      // Waiting for the selected input to go low; the counter doubles as the
      // wait timeout.
      ARM: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (!w_sel_in) begin
          w_cnt_nxt   = CW'(1);
          w_state_nxt = COUNT;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == SAT - CW'(1)) begin
            w_state_nxt     = REPORT;
            w_res_valid_nxt = 1'b1;
            w_res_chan_nxt  = r_cur;
            w_res_dur_nxt   = '0;
            w_res_to_nxt    = 1'b1;
          end
        end
      end

      // Counting low cycles; saturates at SAT instead of wrapping.
      COUNT: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (w_sel_in) begin
          w_state_nxt     = REPORT;
          w_res_valid_nxt = 1'b1;
          w_res_chan_nxt  = r_cur;
          w_res_dur_nxt   = r_cnt;
          w_res_to_nxt    = 1'b0;
        end else if (r_cnt == SAT) begin
          w_state_nxt     = REPORT;
          w_res_valid_nxt = 1'b1;
          w_res_chan_nxt  = r_cur;
          w_res_dur_nxt   = SAT;
          w_res_to_nxt    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      REPORT: begin
        if (res_ready) begin
          w_last_nxt      = r_cur;
          w_res_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign res_valid    = r_res_valid;
  assign res_chan     = r_res_chan;
  assign res_duration = r_res_dur;
  assign res_timeout  = r_res_to;
  assign busy         = (r_state != IDLE);
  assign cur_chan     = r_cur;

endmodule
